// File: rtl/pwm_pkg.sv
// pwm_pkg: register map, counter limit helper, alignment mode and byte-merge helper.
package pwm_pkg;
  localparam logic [6:0] ADDR_OUT_EN = 7'h00;
  localparam logic [6:0] ADDR_PWM_EN = 7'h08;
  localparam logic [6:0] ADDR_PRESC_LO = 7'h10;
  localparam logic [6:0] ADDR_PRESC_HI = 7'h11;
  localparam logic [6:0] ADDR_MODE = 7'h12;
  localparam logic [6:0] ADDR_DUTY = 7'h20;
  typedef enum logic {EDGE, CENTER} mode_t;
  function automatic int maxc(input int w);
    return (1 << w) - 1;
  endfunction
  function automatic logic [15:0] put_byte(input logic [15:0] v, input logic hi, input logic [7:0] d);
    return hi ? {d, v[7:0]} : {v[15:8], d};
  endfunction
endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase: prescaler and period counter shared by all channels; wrap marks the edge where cnt returns to 0.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int PRESC_W = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PRESC_W-1:0] presc,
  input  logic               restart,
  input  mode_t              mode,
  output logic [CNT_W-1:0]   cnt,
  output logic               step,
  output logic               wrap
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(maxc(CNT_W) - 1);
  logic [PRESC_W-1:0] psc;
  logic down;
  assign step = psc == presc;
  assign wrap = step && (mode == CENTER ? down && cnt == CNT_W'(1) : cnt == LAST);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      psc <= '0;
      cnt <= '0;
      down <= 1'b0;
    end else if (restart) begin
      psc <= '0;
      cnt <= '0;
      down <= 1'b0;
    end else begin
      psc <= step ? '0 : psc + 1'b1;
      if (step) begin
        if (wrap) begin
          cnt <= '0;
          down <= 1'b0;
        end else if (mode == CENTER && (down || cnt == LAST)) begin
          cnt <= cnt - 1'b1;
          down <= 1'b1;
        end else cnt <= cnt + 1'b1;
      end
    end
endmodule

// File: rtl/pwm_multi_ch.sv
// pwm_multi_ch: NUM_CH PWM channels with double-buffered duty behind a byte-write port.
// Optional centre-aligned counting (register 0x12 bit0) under PWM_CENTER_ALIGNED_EN.
module pwm_multi_ch
  import pwm_pkg::*;
#(
  parameter int NUM_CH = 16,
  parameter int CNT_W = 8,
  parameter int PRESC_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [6:0]        wr_addr,
  input  logic [7:0]        wr_data,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_tick
);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(maxc(CNT_W));
  logic [NUM_CH-1:0] out_en, pwm_en, nxt;
  logic [PRESC_W-1:0] presc;
  logic [CNT_W-1:0] duty_shadow [NUM_CH];
  logic [CNT_W-1:0] duty_act [NUM_CH];
  logic [CNT_W-1:0] cnt;
  logic step, wrap, acc, presc_wr;
  mode_t mode;
  assign acc = wr_valid && wr_ready;
  assign presc_wr = acc && (wr_addr == ADDR_PRESC_LO || wr_addr == ADDR_PRESC_HI);
  pwm_timebase #(.CNT_W(CNT_W), .PRESC_W(PRESC_W)) u_tb (
    .clk(clk), .rst_n(rst_n), .presc(presc), .restart(presc_wr), .mode(mode),
    .cnt(cnt), .step(step), .wrap(wrap)
  );
  always_comb begin
    nxt = '0;
    for (int i = 0; i < NUM_CH; i++)
      nxt[i] = !out_en[i] ? 1'b0 : !pwm_en[i] ? 1'b1 : duty_act[i] == FULL || cnt < duty_act[i];
  end
`ifdef PWM_CENTER_ALIGNED_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mode <= EDGE;
    else if (acc && wr_addr == ADDR_MODE) mode <= mode_t'(wr_data[0]);
`else
  assign mode = EDGE;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ready <= 1'b0;
      period_tick <= 1'b0;
      pwm_out <= '0;
      out_en <= '0;
      pwm_en <= '0;
      presc <= '0;
      duty_shadow <= '{default: '0};
      duty_act <= '{default: '0};
    end else begin
      wr_ready <= !presc_wr;
      period_tick <= step && wrap;
      pwm_out <= nxt;
      // shadow copy uses pre-edge values, so a write on the wrap edge lands one period later
      if (step && wrap) duty_act <= duty_shadow;
      if (acc) begin
        if (presc_wr) presc <= PRESC_W'(put_byte(16'(presc), wr_addr[0], wr_data));
        for (int i = 0; i < NUM_CH; i++) begin
          if (wr_addr == ADDR_OUT_EN + 7'(i / 8)) out_en[i] <= wr_data[i % 8];
          if (wr_addr == ADDR_PWM_EN + 7'(i / 8)) pwm_en[i] <= wr_data[i % 8];
          if ({wr_addr[6:1], 1'b0} == ADDR_DUTY + 7'(2 * i))
            duty_shadow[i] <= CNT_W'(put_byte(16'(duty_shadow[i]), wr_addr[0], wr_data));
        end
      end
    end
endmodule

// File: tb/tb_pwm_multi_ch.sv
// tb_pwm_multi_ch: directed checks of reset, enables, duty boundaries, prescaler and glitch-free duty update.
module tb_pwm_multi_ch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_valid = 1'b0;
  logic wr_ready;
  logic [6:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [15:0] pwm_out;
  logic period_tick;
  int checks = 0;
  int errors = 0;
  int hi, ticks;

  pwm_multi_ch #(.NUM_CH(16), .CNT_W(8), .PRESC_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .pwm_out(pwm_out), .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    int n = 0;
    while (!wr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!wr_ready) check("wr_ready_timeout", 32'(wr_ready), 32'd1);
    wr_addr = a;
    wr_data = d;
    wr_valid = 1'b1;
    @(posedge clk);
    #1 wr_valid = 1'b0;
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_tick && n < 5000);
    check("tick_seen", 32'(period_tick), 32'd1);
  endtask

  // samples n negedges after the current one; optionally issues a duty[0] write after sample k==at
  task automatic measure(input int n, input int at, input logic [7:0] d, output int h, output int t);
    h = 0;
    t = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (pwm_out[0]) h++;
      if (period_tick) t++;
      if (at != 0 && k == at) begin
        wr_addr = 7'h20;
        wr_data = d;
        wr_valid = 1'b1;
      end
      if (at != 0 && k == at + 1) wr_valid = 1'b0;
    end
  endtask

  initial begin
    wr_valid = 1'b1;
    wr_addr = 7'h00;
    wr_data = 8'hFF;
    repeat (5) @(negedge clk);
    check("rst_pwm_out", 32'(pwm_out), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_tick", 32'(period_tick), 32'd0);
    rst_n = 1'b1;
    wr_valid = 1'b0;
    @(posedge clk);
    #1 check("post_rst_wr_ready", 32'(wr_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 check("post_rst_out_en_clear", 32'(pwm_out), 32'd0);

    wr(7'h00, 8'h01);
    wr(7'h01, 8'h80);
    repeat (2) @(posedge clk);
    #1 check("static_on", 32'(pwm_out), 32'h8001);
    wr(7'h00, 8'h00);
    check("static_off_registered", 32'(pwm_out), 32'h8001);
    @(posedge clk);
    #1 check("static_off_next", 32'(pwm_out), 32'h8000);
    wr(7'h01, 8'h00);
    repeat (2) @(posedge clk);
    #1 check("static_all_off", 32'(pwm_out), 32'd0);

    wr(7'h10, 8'h00);
    wr(7'h20, 8'd128);
    wr(7'h08, 8'h01);
    wr(7'h00, 8'h01);
    wait_tick();
    wait_tick();
    measure(255, 0, 8'h00, hi, ticks);
    check("duty128_high", 32'(hi), 32'd128);
    check("duty128_ticks", 32'(ticks), 32'd1);
    check("other_ch_low", 32'(pwm_out[15:1]), 32'd0);

    wr(7'h21, 8'hFF);
    wr(7'h20, 8'd0);
    wait_tick();
    wait_tick();
    measure(255, 0, 8'h00, hi, ticks);
    check("duty0_high", 32'(hi), 32'd0);

    wr(7'h20, 8'd255);
    wait_tick();
    wait_tick();
    measure(255, 0, 8'h00, hi, ticks);
    check("duty255_high", 32'(hi), 32'd255);

    wr(7'h10, 8'd3);
    check("presc_ready_drop", 32'(wr_ready), 32'd0);
    @(posedge clk);
    #1 check("presc_ready_back", 32'(wr_ready), 32'd1);
    wr(7'h20, 8'd64);
    wait_tick();
    wait_tick();
    measure(1020, 0, 8'h00, hi, ticks);
    check("presc3_high", 32'(hi), 32'd256);
    check("presc3_ticks", 32'(ticks), 32'd1);

    wr(7'h10, 8'h00);
    wr(7'h20, 8'd100);
    wait_tick();
    wait_tick();
    measure(255, 50, 8'd200, hi, ticks);
    check("midwrite_keeps_old", 32'(hi), 32'd100);
    check("midwrite_ticks", 32'(ticks), 32'd1);
    measure(255, 254, 8'd30, hi, ticks);
    check("new_duty_applied", 32'(hi), 32'd200);
    check("wrapwrite_ticks", 32'(ticks), 32'd1);
    measure(255, 0, 8'h00, hi, ticks);
    check("wrapwrite_old_shadow", 32'(hi), 32'd200);
    measure(255, 0, 8'h00, hi, ticks);
    check("wrapwrite_applied_later", 32'(hi), 32'd30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
